l2_pmem_burst_adaptor: RTL and testbench

- Responder on the L2 cache's physical-memory port: accepts 256-bit line read/write requests and returns a one-cycle completion.
- Initiator toward the DRAM model / physical memory: moves each line as BEATS x 64-bit bursts.
- Sits between l2 cache control/datapath (pmem_* side) and the physical memory interface.

---
 rtl/l2_pmem_burst_adaptor.sv | 155 +++++++++++++++
 tb/tb_l2_pmem_burst_adaptor.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_pmem_burst_adaptor.sv
// l2_pmem_burst_adaptor: bridges L2 line requests to BEATS x BURST_WIDTH memory bursts.
// Ports: clk, rst_n (sync, active-low); pmem_* line side toward L2
//   (address/read/write/wdata in, rdata/resp out); mem_* burst side toward
//   physical memory (address/read/write/wdata out, rdata/resp in, error out).
// Option: define L2_PMEM_TIMEOUT_EN to enable the beat watchdog and mem_error.
module l2_pmem_burst_adaptor #(
  parameter int unsigned BURST_WIDTH    = 64,
  parameter int unsigned BEATS          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned LINE_WIDTH    = BEATS * BURST_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            pmem_address,
  input  logic                   pmem_read,
  input  logic                   pmem_write,
  input  logic [LINE_WIDTH-1:0]  pmem_wdata,
  output logic [LINE_WIDTH-1:0]  pmem_rdata,
  output logic                   pmem_resp,
  output logic [31:0]            mem_address,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [BURST_WIDTH-1:0] mem_wdata,
  input  logic [BURST_WIDTH-1:0] mem_rdata,
  input  logic                   mem_resp,
  output logic                   mem_error
);

  localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [31:0] ALIGN = ~(32'(LINE_WIDTH / 8) - 32'd1);

  if (BEATS < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("l2_pmem_burst_adaptor: bad BEATS/TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [LINE_WIDTH-1:0] line_q;
  logic [LINE_WIDTH-1:0] line_next;
  logic                  last_beat;
  logic                  tmo_hit;

  assign last_beat = mem_resp && (cnt == LAST);

  // Line buffer with the current read beat merged in; used so the
  // final beat reaches pmem_rdata on the same edge it is sampled.
  always_comb begin
    line_next = line_q;
    line_next[BURST_WIDTH*cnt +: BURST_WIDTH] = mem_rdata;
  end

  assign mem_wdata = mem_write ?
    line_q[BURST_WIDTH*cnt +: BURST_WIDTH] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      line_q      <= '0;
      pmem_rdata  <= '0;
      pmem_resp   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (pmem_read) begin
            state       <= RD;
            mem_read    <= 1'b1;
            mem_address <= pmem_address & ALIGN;
            // cleared so beats lost to a timeout read back as zero
            line_q      <= '0;
          end else if (pmem_write) begin
            state       <= WR;
            mem_write   <= 1'b1;
            mem_address <= pmem_address & ALIGN;
            line_q      <= pmem_wdata;
          end
        end
        RD: begin
          if (mem_resp) begin
            line_q <= line_next;
          end
          if (last_beat || tmo_hit) begin
            state      <= DONE;
            mem_read   <= 1'b0;
            pmem_resp  <= 1'b1;
            cnt        <= '0;
            pmem_rdata <= tmo_hit ? line_q : line_next;
          end else if (mem_resp) begin
            cnt <= cnt + 1'b1;
          end
        end
        WR: begin
          if (last_beat || tmo_hit) begin
            state     <= DONE;
            mem_write <= 1'b0;
            pmem_resp <= 1'b1;
            cnt       <= '0;
          end else if (mem_resp) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          pmem_resp <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef L2_PMEM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          busy;

  assign busy    = (state == RD) || (state == WR);
  assign tmo_hit = busy && !mem_resp &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      mem_error <= 1'b0;
    end else begin
      if (!busy || mem_resp) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (tmo_hit) begin
        mem_error <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign mem_error = 1'b0;
`endif

endmodule

// File: tb/tb_l2_pmem_burst_adaptor.sv
// tb_l2_pmem_burst_adaptor: directed vectors for l2_pmem_burst_adaptor.
// Drives the L2 side and a scripted memory responder.
module tb_l2_pmem_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;
  logic         mem_error;

  int n_vec = 0;
  int n_bad = 0;
  int hold_bad;
  int addr_bad;
  int lat;

  localparam logic [255:0] RD_LINE = {
    64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] WR_LINE = {
    64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
    64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
  localparam logic [255:0] B_LINE = {
    64'hBBBB_0000_0000_0003, 64'hBBBB_0000_0000_0002,
    64'hBBBB_0000_0000_0001, 64'hBBBB_0000_0000_0000};
  localparam logic [255:0] C_LINE = {
    64'hCCCC_0000_0000_0003, 64'hCCCC_0000_0000_0002,
    64'hCCCC_0000_0000_0001, 64'hCCCC_0000_0000_0000};
  localparam logic [255:0] E_LINE = {
    64'hEEEE_0000_0000_0003, 64'hEEEE_0000_0000_0002,
    64'hEEEE_0000_0000_0001, 64'hEEEE_0000_0000_0000};

  localparam logic [31:0] EVERY = 32'h0000_001E;
  localparam logic [31:0] SPARSE = 32'h0000_009A;

  l2_pmem_burst_adaptor #(
    .BURST_WIDTH(64),
    .BEATS(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pmem_address(pmem_address),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp),
    .mem_address(mem_address),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_resp(mem_resp),
    .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic rd, input logic wr,
                     input logic [31:0] a,
                     input logic [255:0] wd);
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = a;
    pmem_wdata   = wd;
    tick();
  endtask

  // Cycle 1 is the first cycle after acceptance; mask bit c gives
  // mem_resp in cycle c. lat is the cycle pmem_resp is seen in.
  task automatic run(input logic [255:0] rb,
                     input logic [255:0] wd,
                     input logic [31:0] mask,
                     input logic keep,
                     output int lt);
    int cyc;
    int k;
    logic [31:0] a0;
    cyc = 1;
    k = 0;
    a0 = mem_address;
    hold_bad = 0;
    addr_bad = 0;
    while (!pmem_resp && cyc < 60) begin
      if (mem_address != a0) addr_bad++;
      if (mem_write && k < 4 && mem_wdata != wd[64*k +: 64])
        hold_bad++;
      if (cyc < 32 && mask[cyc] && k < 4) begin
        mem_resp  = 1'b1;
        mem_rdata = rb[64*k +: 64];
        k++;
      end else begin
        mem_resp  = 1'b0;
        mem_rdata = '0;
      end
      tick();
      cyc++;
    end
    mem_resp  = 1'b0;
    mem_rdata = '0;
    if (!keep) begin
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
    end
    lt = cyc;
  endtask

  initial begin
    rst_n = 1'b0;
    pmem_address = '0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_wdata = '0;
    mem_rdata = '0;
    mem_resp = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    chk("rst_resp", 256'(pmem_resp), 256'd0);
    chk("rst_rdata", pmem_rdata, 256'd0);
    chk("rst_mrd", 256'(mem_read), 256'd0);
    chk("rst_mwr", 256'(mem_write), 256'd0);
    chk("rst_addr", 256'(mem_address), 256'd0);
    chk("rst_wdata", 256'(mem_wdata), 256'd0);
    chk("rst_err", 256'(mem_error), 256'd0);
    tick();

    // basic read, mem_resp every cycle
    req(1'b1, 1'b0, 32'h0000_1234, '0);
    chk("rd_addr", 256'(mem_address), 256'h1220);
    chk("rd_mrd", 256'(mem_read), 256'd1);
    chk("rd_mwr", 256'(mem_write), 256'd0);
    run(RD_LINE, '0, EVERY, 1'b0, lat);
    chk("rd_lat", 256'(lat), 256'd5);
    chk("rd_line", pmem_rdata, RD_LINE);
    chk("rd_addr_stable", 256'(addr_bad), 256'd0);
    chk("rd_mrd_done", 256'(mem_read), 256'd0);
    tick();
    chk("rd_one_pulse", 256'(pmem_resp), 256'd0);

    // write with stalls between beats
    req(1'b0, 1'b1, 32'h8000_00E0, WR_LINE);
    chk("wr_addr", 256'(mem_address), 256'h8000_00E0);
    chk("wr_mwr", 256'(mem_write), 256'd1);
    chk("wr_beat0", 256'(mem_wdata), 256'(WR_LINE[63:0]));
    run('0, WR_LINE, SPARSE, 1'b0, lat);
    chk("wr_lat", 256'(lat), 256'd8);
    chk("wr_hold", 256'(hold_bad), 256'd0);
    chk("wr_keeps_rdata", pmem_rdata, RD_LINE);
    tick();
    chk("wr_one_pulse", 256'(pmem_resp), 256'd0);

    // read and write together: read wins
    req(1'b1, 1'b1, 32'h0000_0047, WR_LINE);
    chk("both_mrd", 256'(mem_read), 256'd1);
    chk("both_mwr", 256'(mem_write), 256'd0);
    chk("both_addr", 256'(mem_address), 256'h40);
    run(B_LINE, '0, EVERY, 1'b0, lat);
    chk("both_line", pmem_rdata, B_LINE);
    tick();
    req(1'b0, 1'b1, 32'h0000_0080, C_LINE);
    run('0, C_LINE, EVERY, 1'b0, lat);
    chk("both_wr_lat", 256'(lat), 256'd5);
    chk("both_keep", pmem_rdata, B_LINE);
    tick();

    // read held through pmem_resp, mem_resp glitch while idle
    req(1'b1, 1'b0, 32'h0000_0100, '0);
    run(E_LINE, '0, EVERY, 1'b1, lat);
    chk("hold_lat", 256'(lat), 256'd5);
    pmem_address = 32'h0000_0200;
    mem_resp = 1'b1;
    tick();
    chk("hold_idle_resp", 256'(pmem_resp), 256'd0);
    chk("hold_idle_mrd", 256'(mem_read), 256'd0);
    tick();
    chk("hold_2nd_mrd", 256'(mem_read), 256'd1);
    chk("hold_2nd_addr", 256'(mem_address), 256'h200);
    chk("hold_2nd_resp", 256'(pmem_resp), 256'd0);
    run(C_LINE, '0, EVERY, 1'b0, lat);
    chk("hold_2nd_lat", 256'(lat), 256'd5);
    chk("hold_2nd_line", pmem_rdata, C_LINE);
    tick();

    // reset after two read beats
    req(1'b1, 1'b0, 32'h0000_0300, '0);
    mem_resp = 1'b1;
    mem_rdata = 64'hDEAD_0000_0000_0000;
    tick();
    mem_rdata = 64'hDEAD_0000_0000_0001;
    tick();
    mem_resp = 1'b0;
    mem_rdata = '0;
    pmem_read = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_resp", 256'(pmem_resp), 256'd0);
    chk("mid_rst_mrd", 256'(mem_read), 256'd0);
    chk("mid_rst_addr", 256'(mem_address), 256'd0);
    chk("mid_rst_rdata", pmem_rdata, 256'd0);
    tick();
    chk("mid_rst_idle", 256'(mem_read), 256'd0);
    req(1'b1, 1'b0, 32'h0000_0340, '0);
    run(E_LINE, '0, EVERY, 1'b0, lat);
    chk("post_rst_lat", 256'(lat), 256'd5);
    chk("post_rst_line", pmem_rdata, E_LINE);
    tick();

`ifdef L2_PMEM_TIMEOUT_EN
    req(1'b1, 1'b0, 32'h0000_0400, '0);
    run(E_LINE, '0, 32'h0, 1'b0, lat);
    chk("tmo_lat", 256'(lat), 256'd9);
    chk("tmo_err", 256'(mem_error), 256'd1);
    chk("tmo_line", pmem_rdata, 256'd0);
    tick();
    chk("tmo_sticky", 256'(mem_error), 256'd1);
`else
    begin
      int seen;
      seen = 0;
      req(1'b1, 1'b0, 32'h0000_0400, '0);
      for (int i = 0; i < 100; i++) begin
        if (pmem_resp) seen++;
        tick();
      end
      chk("notmo_resp", 256'(seen), 256'd0);
      chk("notmo_mrd", 256'(mem_read), 256'd1);
      chk("notmo_err", 256'(mem_error), 256'd0);
      run(B_LINE, '0, EVERY, 1'b0, lat);
      chk("notmo_lat", 256'(lat), 256'd5);
      chk("notmo_line", pmem_rdata, B_LINE);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
